// File: rtl/rsa_modexp_stream.sv
// Streaming RSA engine: one W-bit word per transaction, m^E or c^D mod N,
// constant-time left-to-right square-and-multiply over interleaved shift-add multiplies.
module rsa_modexp_stream #(
    parameter int unsigned W     = 14,
    parameter int unsigned EXP_W = 9,
    parameter int unsigned N     = 10403,
    parameter int unsigned E     = 71,
    parameter int unsigned D     = 431
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_mode,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_err,
    output logic         busy
);

    localparam int unsigned CNT_W = (W > 1) ? $clog2(W) : 1;
    localparam int unsigned BIT_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;
    localparam logic [W+1:0]       N_P      = (W+2)'(N);
    localparam logic [W-1:0]       N_D      = W'(N);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(W - 1);
    localparam logic [BIT_W-1:0]   BIT_LAST = BIT_W'(EXP_W - 1);
    localparam logic [EXP_W-1:0]   EXP_ENC  = EXP_W'(E);
    localparam logic [EXP_W-1:0]   EXP_DEC  = EXP_W'(D);

    // Reject moduli that do not fit, even moduli and oversized exponents.
    if ((64'(N) >= (64'd1 << W)) || ((N % 2) == 0) || (N < 3) ||
        (64'(E) >= (64'd1 << EXP_W)) || (64'(D) >= (64'd1 << EXP_W))) begin : g_param_check
        $error("rsa_modexp_stream: illegal N/E/D parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_SQR,
        S_MUL,
        S_DONE
    } state_t;

    state_t           r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [W-1:0]     r_out_data;
    logic             r_out_err;
    logic             r_busy;
    logic             r_mode;
    logic [W-1:0]     r_data;
    logic [W-1:0]     r_base;
    logic [W-1:0]     r_acc;
    logic [EXP_W-1:0] r_exp;
    logic [BIT_W-1:0] r_bit_idx;
    logic [CNT_W-1:0] r_mm_cnt;
    logic [W+1:0]     r_p;

    logic [W-1:0]     w_b;
    logic             w_b_bit;
    logic [W+1:0]     w_p2;
    logic [W+1:0]     w_add;
    logic [W+1:0]     w_sub1;
    logic [W+1:0]     w_sub2;
    logic [W-1:0]     w_prod;
    logic             w_last_mm;

    // One step of p = 2p + b_i*a, reduced by at most two subtractions of N.
    assign w_b       = (r_state == S_SQR) ? r_acc : r_base;
    assign w_b_bit   = w_b[r_mm_cnt];
    assign w_p2      = r_p << 1;
    assign w_add     = w_p2 + (w_b_bit ? {2'b00, r_acc} : '0);
    assign w_sub1    = (w_add >= N_P) ? (w_add - N_P) : w_add;
    assign w_sub2    = (w_sub1 >= N_P) ? (w_sub1 - N_P) : w_sub1;
    assign w_prod    = w_sub2[W-1:0];
    assign w_last_mm = (r_mm_cnt == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_err   <= 1'b0;
            r_busy      <= 1'b0;
            r_mode      <= 1'b0;
            r_data      <= '0;
            r_base      <= '0;
            r_acc       <= '0;
            r_exp       <= '0;
            r_bit_idx   <= '0;
            r_mm_cnt    <= CNT_LAST;
            r_p         <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_mode     <= in_mode;
                        r_data     <= in_data;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (r_data >= N_D) begin
                        r_out_data  <= '0;
                        r_out_err   <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_base    <= r_data;
                        r_acc     <= W'(1);
                        r_exp     <= r_mode ? EXP_DEC : EXP_ENC;
                        r_bit_idx <= BIT_LAST;
                        r_mm_cnt  <= CNT_LAST;
                        r_p       <= '0;
                        r_state   <= S_SQR;
                    end
                end
                S_SQR, S_MUL: begin
                    if (w_last_mm) begin
                        r_p      <= '0;
                        r_mm_cnt <= CNT_LAST;
                        if (r_state == S_SQR) begin
                            r_acc   <= w_prod;
                            r_state <= S_MUL;
                        end else begin
                            // MUL always runs; only the commit depends on the exponent bit.
                            if (r_exp[r_bit_idx]) begin
                                r_acc <= w_prod;
                            end
                            if (r_bit_idx == '0) begin
                                r_out_data  <= r_exp[r_bit_idx] ? w_prod : r_acc;
                                r_out_err   <= 1'b0;
                                r_out_valid <= 1'b1;
                                r_state     <= S_DONE;
                            end else begin
                                r_bit_idx <= r_bit_idx - BIT_W'(1);
                                r_state   <= S_SQR;
                            end
                        end
                    end else begin
                        r_p      <= w_sub2;
                        r_mm_cnt <= r_mm_cnt - CNT_W'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_err   = r_out_err;
    assign busy      = r_busy;

endmodule

// File: tb/tb_rsa_modexp_stream.sv
// Self-checking bench for rsa_modexp_stream: scoreboard of expected results
// pushed on accept, popped and compared when out_valid appears.
module tb_rsa_modexp_stream;

    localparam int unsigned W     = 14;
    localparam int unsigned EXP_W = 9;
    localparam int unsigned N     = 10403;
    localparam int unsigned E     = 71;
    localparam int unsigned D     = 431;
    localparam int LAT     = 254;
    localparam int ERR_LAT = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic         in_mode;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_err;
    logic         busy;

    typedef struct {
        logic [W-1:0] data;
        logic         err;
        int           acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    int   n_acc = 0;

    rsa_modexp_stream #(
        .W(W), .EXP_W(EXP_W), .N(N), .E(E), .D(D)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && in_valid && in_ready) n_acc <= n_acc + 1;
    end

    initial begin
        #(10 * 80000);
        $display("FAIL watchdog: simulation exceeded 80000 cycles");
        $fatal(1, "watchdog");
    end

    // Behavioural reference: repeated multiplication, no square-and-multiply.
    function automatic int unsigned modexp(input int unsigned b, input int unsigned e);
        longint unsigned r = 1;
        for (int unsigned i = 0; i < e; i++) r = (r * longint'(b)) % longint'(N);
        return int'(r);
    endfunction

    // Present a word from a negedge, wait for in_ready, record expectation at accept.
    task automatic send(input logic mode, input logic [W-1:0] data,
                        input logic [W-1:0] exp_d, input logic exp_e);
        int t = 0;
        in_valid = 1'b1;
        in_mode  = mode;
        in_data  = data;
        while (in_ready !== 1'b1 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        sb.push_back('{data: exp_d, err: exp_e, acc_cyc: cyc});
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = W'($urandom);
        in_mode  = 1'($urandom);
    endtask

    // Wait (bounded) for out_valid; returns observation plus the popped expectation.
    task automatic wait_out(output bit seen, output logic [W-1:0] d, output logic e,
                            output int lat, output exp_t ex);
        seen = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (out_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        d = out_data;
        e = out_err;
        if (sb.size() > 0) ex = sb.pop_front();
        else ex = '{data: '0, err: 1'b0, acc_cyc: 0};
        lat = cyc - ex.acc_cyc;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_mode = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({in_ready, out_valid, out_data, out_err, busy} !== {1'b1, 1'b0, W'(0), 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_values: got rdy=%b vld=%b data=%0d err=%b busy=%b, want rdy=1 vld=0 data=0 err=0 busy=0",
                     in_ready, out_valid, out_data, out_err, busy);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit seen; logic [W-1:0] d; logic e; int lat; exp_t ex;
        send(1'b0, W'(3763), W'(modexp(3763, E)), 1'b0);
        repeat (98) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_busy: got busy=%b want 1", busy);
        end
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            n_bad++;
            $display("FAIL mid_reset: got rdy=%b vld=%b busy=%b want rdy=1 vld=0 busy=0",
                     in_ready, out_valid, busy);
        end
        rst_n = 1'b1;
        sb.delete();
        @(negedge clk);
        send(1'b0, W'(1234), W'(modexp(1234, E)), 1'b0);
        wait_out(seen, d, e, lat, ex);
        n_cmp++;
        if (!seen || d !== ex.data || e !== ex.err || lat != LAT) begin
            n_bad++;
            $display("FAIL after_reset: got seen=%0d data=%0d err=%b lat=%0d want data=%0d err=%b lat=%0d",
                     seen, d, e, lat, ex.data, ex.err, LAT);
        end
        @(negedge clk);
    endtask

    task automatic test_encrypt_boundary();
        bit seen; logic [W-1:0] d; logic e; int lat; exp_t ex;
        int unsigned ms[3] = '{0, 1, N - 1};
        for (int i = 0; i < 3; i++) begin
            send(1'b0, W'(ms[i]), W'(ms[i]), 1'b0);
            wait_out(seen, d, e, lat, ex);
            n_cmp++;
            if (!seen || d !== ex.data || e !== 1'b0 || lat != LAT) begin
                n_bad++;
                $display("FAIL enc_boundary m=%0d: got seen=%0d data=%0d err=%b lat=%0d want data=%0d err=0 lat=%0d",
                         ms[i], seen, d, e, lat, ms[i], LAT);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_error();
        bit seen; logic [W-1:0] d; logic e; int lat; exp_t ex;
        int unsigned bad[2] = '{N, 16383};
        for (int i = 0; i < 2; i++) begin
            send(1'(i), W'(bad[i]), W'(0), 1'b1);
            wait_out(seen, d, e, lat, ex);
            n_cmp++;
            if (!seen || d !== W'(0) || e !== 1'b1 || lat != ERR_LAT) begin
                n_bad++;
                $display("FAIL err_input %0d: got seen=%0d data=%0d err=%b lat=%0d want data=0 err=1 lat=%0d",
                         bad[i], seen, d, e, lat, ERR_LAT);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_round_trip();
        bit seen; logic [W-1:0] d; logic e; int lat; exp_t ex;
        int unsigned m, c;
        for (int i = 0; i < 63; i++) begin
            m = (i == 0) ? 1234 : (i == 1) ? 3763 : (i == 2) ? 201 : $urandom_range(0, N - 1);
            c = modexp(m, E);
            send(1'b0, W'(m), W'(c), 1'b0);
            wait_out(seen, d, e, lat, ex);
            n_cmp++;
            if (!seen || d !== ex.data || e !== 1'b0 || lat != LAT) begin
                n_bad++;
                $display("FAIL rt_encrypt m=%0d: got seen=%0d data=%0d err=%b lat=%0d want data=%0d err=0 lat=%0d",
                         m, seen, d, e, lat, c, LAT);
            end
            @(negedge clk);
            send(1'b1, W'(c), W'(m), 1'b0);
            wait_out(seen, d, e, lat, ex);
            n_cmp++;
            if (!seen || d !== ex.data || e !== 1'b0 || lat != LAT) begin
                n_bad++;
                $display("FAIL rt_decrypt c=%0d: got seen=%0d data=%0d err=%b lat=%0d want data=%0d err=0 lat=%0d",
                         c, seen, d, e, lat, m, LAT);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        bit seen; logic [W-1:0] d; logic e; int lat; exp_t ex;
        out_ready = 1'b0;
        send(1'b0, W'(201), W'(modexp(201, E)), 1'b0);
        wait_out(seen, d, e, lat, ex);
        n_cmp++;
        if (!seen || d !== ex.data || e !== 1'b0 || lat != LAT) begin
            n_bad++;
            $display("FAIL bp_result: got seen=%0d data=%0d err=%b lat=%0d want data=%0d err=0 lat=%0d",
                     seen, d, e, lat, ex.data, LAT);
        end
        for (int i = 0; i < 40; i++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== ex.data || out_err !== 1'b0 || in_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL bp_hold cycle %0d: got vld=%b data=%0d err=%b rdy=%b want vld=1 data=%0d err=0 rdy=0",
                         i, out_valid, out_data, out_err, in_ready, ex.data);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_release: got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        int unsigned words[3] = '{1234, 201, 3763};
        int cy[3];
        int acc0 = n_acc;
        out_ready = 1'b1;
        fork
            begin : drv
                int j = 0;
                int t = 0;
                in_valid = 1'b1;
                while (j < 3 && t < 2000) begin
                    if (in_ready === 1'b1) begin
                        in_mode = 1'b0;
                        in_data = W'(words[j]);
                        sb.push_back('{data: W'(modexp(words[j], E)), err: 1'b0, acc_cyc: cyc});
                        cy[j] = cyc;
                        j++;
                    end else begin
                        in_data = W'($urandom);
                        in_mode = 1'($urandom);
                    end
                    @(negedge clk);
                    t++;
                end
                in_valid = 1'b0;
            end
            begin : col
                bit seen; logic [W-1:0] d; logic e; int lat; exp_t ex;
                for (int k = 0; k < 3; k++) begin
                    wait_out(seen, d, e, lat, ex);
                    n_cmp++;
                    if (!seen || d !== ex.data || e !== 1'b0 || lat != LAT) begin
                        n_bad++;
                        $display("FAIL b2b word %0d: got seen=%0d data=%0d err=%b lat=%0d want data=%0d err=0 lat=%0d",
                                 k, seen, d, e, lat, ex.data, LAT);
                    end
                    @(negedge clk);
                end
            end
        join
        repeat (5) @(negedge clk);
        n_cmp++;
        if (n_acc - acc0 != 3) begin
            n_bad++;
            $display("FAIL b2b_accepts: got %0d want 3", n_acc - acc0);
        end
        n_cmp++;
        if (cy[1] - cy[0] != LAT + 1 || cy[2] - cy[1] != LAT + 1) begin
            n_bad++;
            $display("FAIL b2b_spacing: got %0d,%0d want %0d,%0d",
                     cy[1] - cy[0], cy[2] - cy[1], LAT + 1, LAT + 1);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_reset_mid();
        test_encrypt_boundary();
        test_error();
        test_round_trip();
        test_backpressure();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
